matmul_param_unit: RTL and testbench

Parametrised successor to the fixed 4x4, 4-bit matrix multiply engine in the TensorFlowE accelerator. It computes R = A x B for square NxN matrices of DATA_W-bit elements, one MAC per clock. The block captures its operands at start, supports signed or unsigned elements, and narrows results by runtime-selectable saturation or wrap with an overflow flag. It sits behind the tile's control FSM, which uses a start/busy/done handshake.

---
 rtl/matmul_pkg.sv | 38 +++
 rtl/matmul_narrow.sv | 51 +++++
 rtl/matmul_param_unit.sv | 196 +++++++++++++++++++
 tb/tb_matmul_param_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_pkg
// Purpose  : Shared types and helper functions for the parametrised matrix
//            multiply unit: FSM state encoding, the minimum accumulator width
//            and the narrowing bounds for signed/unsigned elements.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Smallest accumulator that can hold N products of two DATA_W-bit values.
  function automatic int acc_width(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

  // Lowest value representable in a DATA_W-bit element.
  function automatic logic signed [63:0] narrow_min(input int is_signed, input int data_w);
    if (is_signed != 0) return -(64'sd1 <<< (data_w - 1));
    return 64'sd0;
  endfunction

  // Highest value representable in a DATA_W-bit element.
  function automatic logic signed [63:0] narrow_max(input int is_signed, input int data_w);
    if (is_signed != 0) return (64'sd1 <<< (data_w - 1)) - 64'sd1;
    return (64'sd1 <<< data_w) - 64'sd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_narrow.sv
`default_nettype none
// ============================================================================
// Module   : matmul_narrow
// Purpose  : Combinational narrowing of an accumulator to a DATA_W element,
//            either clamping to the nearest bound or keeping the low bits.
// Ports    : i_acc    [ACC_W-1:0]  accumulated dot product
//            i_sat_en              1 = saturate, 0 = wrap
//            o_elem   [DATA_W-1:0] narrowed element
//            o_ovf                 accumulator outside the element range
// Revision : 1.0 - initial release
// ============================================================================
module matmul_narrow
  import matmul_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = acc_width(4, 4),
  parameter int SIGNED = 0
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic              i_sat_en,
  output logic [DATA_W-1:0] o_elem,
  output logic              o_ovf
);

  localparam logic signed [63:0] c_lo      = narrow_min(SIGNED, DATA_W);
  localparam logic signed [63:0] c_hi      = narrow_max(SIGNED, DATA_W);
  localparam logic [DATA_W-1:0]  c_lo_elem = c_lo[DATA_W-1:0];
  localparam logic [DATA_W-1:0]  c_hi_elem = c_hi[DATA_W-1:0];

  logic               w_ext;
  logic signed [63:0] w_val;
  logic               w_below;
  logic               w_above;

  always_comb begin
    // Widen to 64 bits so a single signed compare covers both element modes.
    w_ext   = (SIGNED != 0) ? i_acc[ACC_W-1] : 1'b0;
    w_val   = {{(64 - ACC_W){w_ext}}, i_acc};
    w_below = (w_val < c_lo);
    w_above = (w_val > c_hi);
    o_ovf   = w_below | w_above;
    o_elem  = i_acc[DATA_W-1:0];
    if (i_sat_en && w_below) begin
      o_elem = c_lo_elem;
    end else if (i_sat_en && w_above) begin
      o_elem = c_hi_elem;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matmul_param_unit.sv
`default_nettype none
// ============================================================================
// Module   : matmul_param_unit
// Purpose  : R = A x B for NxN matrices of DATA_W-bit elements, one MAC per
//            clock, with operand capture, signed/unsigned arithmetic and
//            runtime-selectable saturate/wrap narrowing.
// Ports    : clk                  rising-edge clock
//            rst                  asynchronous active-low reset
//            start                request, sampled only in IDLE
//            sat_en               1 = saturate, 0 = wrap (captured in LOAD)
//            matrixA/matrixB      flattened operands, (r,c) at DATA_W*(r*N+c)
//            result               flattened product, same layout
//            busy                 high in every state except IDLE
//            done                 one-cycle pulse when result updates
//            overflow             some element of last result was out of range
// Revision : 1.0 - initial release
// ============================================================================
module matmul_param_unit
  import matmul_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int N      = 4,
  parameter int SIGNED = 0,
  parameter int ACC_W  = acc_width(DATA_W, N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sat_en,
  input  logic [N*N*DATA_W-1:0] matrixA,
  input  logic [N*N*DATA_W-1:0] matrixB,
  output logic [N*N*DATA_W-1:0] result,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int c_vec_w = N * N * DATA_W;
  localparam int c_k_w   = $clog2(N + 1);
  localparam int c_i_w   = $clog2(N);
  localparam logic [c_k_w-1:0] c_k_end  = c_k_w'(N);
  localparam logic [c_i_w-1:0] c_i_last = c_i_w'(N - 1);

  if (ACC_W < acc_width(DATA_W, N)) begin : g_bad_acc_w
    $error("matmul_param_unit: ACC_W smaller than 2*DATA_W+clog2(N)");
  end
  if (DATA_W < 2 || DATA_W > 16 || N < 2 || N > 8) begin : g_bad_dims
    $error("matmul_param_unit: DATA_W must be 2..16 and N must be 2..8");
  end

  state_e             state_q,  state_d;
  logic [c_vec_w-1:0] a_q,      a_d;
  logic [c_vec_w-1:0] b_q,      b_d;
  logic               sat_q,    sat_d;
  logic [c_i_w-1:0]   i_q,      i_d;
  logic [c_i_w-1:0]   j_q,      j_d;
  logic [c_k_w-1:0]   k_q,      k_d;
  logic [ACC_W-1:0]   acc_q,    acc_d;
  logic               ovf_q,    ovf_d;
  logic [c_vec_w-1:0] rint_q,   rint_d;
  logic [c_vec_w-1:0] result_q, result_d;
  logic               oflow_q,  oflow_d;

  int                 w_k_idx;
  logic [DATA_W-1:0]  w_a_elem;
  logic [DATA_W-1:0]  w_b_elem;
  logic [ACC_W-1:0]   w_a_ext;
  logic [ACC_W-1:0]   w_b_ext;
  logic [ACC_W-1:0]   w_prod;
  logic [DATA_W-1:0]  w_elem;
  logic               w_elem_ovf;

  // MAC operand fetch. k reaches N on the narrowing cycle, where the product
  // is unused; the index is clamped so the select never leaves the vector.
  always_comb begin
    w_k_idx  = (k_q == c_k_end) ? 0 : int'(k_q);
    w_a_elem = a_q[DATA_W * (int'(i_q) * N + w_k_idx) +: DATA_W];
    w_b_elem = b_q[DATA_W * (w_k_idx * N + int'(j_q)) +: DATA_W];
    w_a_ext  = {{(ACC_W - DATA_W){(SIGNED != 0) && w_a_elem[DATA_W-1]}}, w_a_elem};
    w_b_ext  = {{(ACC_W - DATA_W){(SIGNED != 0) && w_b_elem[DATA_W-1]}}, w_b_elem};
    // Low ACC_W bits of the product are exact for two's complement as well.
    w_prod   = w_a_ext * w_b_ext;
  end

  matmul_narrow #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_narrow (
    .i_acc    (acc_q),
    .i_sat_en (sat_q),
    .o_elem   (w_elem),
    .o_ovf    (w_elem_ovf)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sat_d    = sat_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    rint_d   = rint_q;
    result_d = result_q;
    oflow_d  = oflow_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        a_d     = matrixA;
        b_d     = matrixB;
        sat_d   = sat_en;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        acc_d   = '0;
        ovf_d   = 1'b0;
        state_d = CALC;
      end
      CALC: begin
        if (k_q != c_k_end) begin
          acc_d = acc_q + w_prod;
          k_d   = k_q + 1'b1;
        end else begin
          // Dot product complete: narrow it, then step row-major.
          rint_d[DATA_W * (int'(i_q) * N + int'(j_q)) +: DATA_W] = w_elem;
          ovf_d = ovf_q | w_elem_ovf;
          acc_d = '0;
          k_d   = '0;
          if (j_q == c_i_last) begin
            j_d = '0;
            if (i_q == c_i_last) begin
              state_d = STORE;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      STORE: begin
        result_d = rint_q;
        oflow_d  = ovf_q;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sat_q    <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      rint_q   <= '0;
      result_q <= '0;
      oflow_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sat_q    <= sat_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      rint_q   <= rint_d;
      result_q <= result_d;
      oflow_q  <= oflow_d;
    end
  end

  assign result   = result_q;
  assign overflow = oflow_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_matmul_param_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_param_unit
// Purpose  : Directed checks of matmul_param_unit in three configurations:
//            default unsigned 4x4x4b, signed 4x4x4b, and unsigned 3x3x8b.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_param_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default configuration: DATA_W=4, N=4, unsigned.
  logic        start0, sat0, busy0, done0, ovf0;
  logic [63:0] a0, b0, res0;
  // Signed configuration: DATA_W=4, N=4.
  logic        start1, sat1, busy1, done1, ovf1;
  logic [63:0] a1, b1, res1;
  // Small configuration: DATA_W=8, N=3, unsigned.
  logic        start2, sat2, busy2, done2, ovf2;
  logic [71:0] a2, b2, res2;

  int checks = 0;
  int errors = 0;
  int lat, pulses, bcy;

  // Negedge c of run_op follows rising edge E0+c-1, so done after edge
  // E0+N*N*(N+1)+2 appears at c = N*N*(N+1)+3.
  localparam int LAT4 = 4 * 4 * 5 + 3;
  localparam int LAT3 = 3 * 3 * 4 + 3;

  localparam logic [63:0] IDENT = 64'h1000_0100_0010_0001;
  localparam logic [63:0] PATT  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DIAG2 = 64'h2000_0200_0020_0002;

  matmul_param_unit u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .sat_en(sat0),
    .matrixA(a0), .matrixB(b0), .result(res0),
    .busy(busy0), .done(done0), .overflow(ovf0)
  );

  matmul_param_unit #(.DATA_W(4), .N(4), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sat_en(sat1),
    .matrixA(a1), .matrixB(b1), .result(res1),
    .busy(busy1), .done(done1), .overflow(ovf1)
  );

  matmul_param_unit #(.DATA_W(8), .N(3), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .sat_en(sat2),
    .matrixA(a2), .matrixB(b2), .result(res2),
    .busy(busy2), .done(done2), .overflow(ovf2)
  );

  // Pulse start on one instance and watch 120 cycles. With scramble set the
  // DUT0 operands change every cycle after LOAD and start is pulsed mid-CALC.
  task automatic run_op(input int sel, input bit scramble,
                        output int o_lat, output int o_pulses, output int o_busy);
    logic d, bz;
    o_lat = -1; o_pulses = 0; o_busy = 0;
    @(negedge clk);
    case (sel)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      case (sel)
        0:       start0 = scramble && (c == 20);
        1:       start1 = 1'b0;
        default: start2 = 1'b0;
      endcase
      if (scramble && c >= 2) begin
        a0   = {$urandom, $urandom};
        b0   = {$urandom, $urandom};
        sat0 = 1'($urandom_range(0, 1));
      end
      case (sel)
        0:       begin d = done0; bz = busy0; end
        1:       begin d = done1; bz = busy1; end
        default: begin d = done2; bz = busy2; end
      endcase
      if (d) begin
        o_pulses++;
        if (o_lat < 0) o_lat = c;
      end
      if (bz) o_busy++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start0 = 0; sat0 = 0; a0 = '0; b0 = '0;
    start1 = 0; sat1 = 0; a1 = '0; b1 = '0;
    start2 = 0; sat2 = 0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({res0, busy0, done0, ovf0} !== 67'b0) begin
      errors++; $display("FAIL reset_dut0: got res=%h busy=%b done=%b ovf=%b expected all zero", res0, busy0, done0, ovf0);
    end
    checks++;
    if ({res1, busy1, done1, ovf1} !== 67'b0) begin
      errors++; $display("FAIL reset_dut1: got res=%h busy=%b done=%b ovf=%b expected all zero", res1, busy1, done1, ovf1);
    end
    checks++;
    if ({res2, busy2, done2, ovf2} !== 75'b0) begin
      errors++; $display("FAIL reset_dut2: got res=%h busy=%b done=%b ovf=%b expected all zero", res2, busy2, done2, ovf2);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    a0 = IDENT; b0 = PATT; sat0 = 1'b0;
    run_op(0, 1'b0, lat, pulses, bcy);
    checks++;
    if (res0 !== PATT) begin errors++; $display("FAIL identity_result: got %h expected %h", res0, PATT); end
    checks++;
    if (ovf0 !== 1'b0) begin errors++; $display("FAIL identity_ovf: got %b expected 0", ovf0); end
    checks++;
    if (lat != LAT4) begin errors++; $display("FAIL identity_latency: got %0d expected %0d", lat, LAT4); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL identity_done_pulses: got %0d expected 1", pulses); end
    // LOAD + 80 CALC + STORE + DONE.
    checks++;
    if (bcy != LAT4) begin errors++; $display("FAIL identity_busy_cycles: got %0d expected %0d", bcy, LAT4); end
  endtask

  task automatic test_unsigned_overflow();
    a0 = '1; b0 = '1; sat0 = 1'b1;
    run_op(0, 1'b0, lat, pulses, bcy);
    checks++;
    if (res0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL usat_result: got %h expected ffffffffffffffff", res0); end
    checks++;
    if (ovf0 !== 1'b1) begin errors++; $display("FAIL usat_ovf: got %b expected 1", ovf0); end
    sat0 = 1'b0;
    run_op(0, 1'b0, lat, pulses, bcy);
    checks++;
    if (res0 !== 64'h4444_4444_4444_4444) begin errors++; $display("FAIL uwrap_result: got %h expected 4444444444444444", res0); end
    checks++;
    if (ovf0 !== 1'b1) begin errors++; $display("FAIL uwrap_ovf: got %b expected 1", ovf0); end
    checks++;
    if (lat != LAT4) begin errors++; $display("FAIL uwrap_latency: got %0d expected %0d", lat, LAT4); end
  endtask

  task automatic test_capture();
    // diag(2) x PATT: 2*v, clamped to 15 for v >= 8.
    a0 = DIAG2; b0 = PATT; sat0 = 1'b1;
    run_op(0, 1'b1, lat, pulses, bcy);
    checks++;
    if (res0 !== 64'hFFFF_FFFF_ECA8_6420) begin errors++; $display("FAIL capture_result: got %h expected ffffffffeca86420", res0); end
    checks++;
    if (ovf0 !== 1'b1) begin errors++; $display("FAIL capture_ovf: got %b expected 1", ovf0); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL capture_done_pulses: got %0d expected 1", pulses); end
    checks++;
    if (lat != LAT4) begin errors++; $display("FAIL capture_latency: got %0d expected %0d", lat, LAT4); end
  endtask

  task automatic test_reset_mid_calc();
    a0 = IDENT; b0 = PATT; sat0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (39) @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL midcalc_busy_before: got %b expected 1", busy0); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({res0, busy0, done0, ovf0} !== 67'b0) begin
      errors++; $display("FAIL midcalc_reset: got res=%h busy=%b done=%b ovf=%b expected all zero", res0, busy0, done0, ovf0);
    end
    @(negedge clk); rst = 1'b1;
    run_op(0, 1'b0, lat, pulses, bcy);
    checks++;
    if (res0 !== PATT) begin errors++; $display("FAIL after_reset_result: got %h expected %h", res0, PATT); end
    checks++;
    if (lat != LAT4) begin errors++; $display("FAIL after_reset_latency: got %0d expected %0d", lat, LAT4); end
  endtask

  task automatic test_signed();
    // (-1)*1 summed four times = -4.
    a1 = 64'hFFFF_FFFF_FFFF_FFFF; b1 = 64'h1111_1111_1111_1111; sat1 = 1'b1;
    run_op(1, 1'b0, lat, pulses, bcy);
    checks++;
    if (res1 !== 64'hCCCC_CCCC_CCCC_CCCC) begin errors++; $display("FAIL signed_neg_result: got %h expected cccccccccccccccc", res1); end
    checks++;
    if (ovf1 !== 1'b0) begin errors++; $display("FAIL signed_neg_ovf: got %b expected 0", ovf1); end
    checks++;
    if (lat != LAT4) begin errors++; $display("FAIL signed_latency: got %0d expected %0d", lat, LAT4); end
    // (-8)*(-8)*4 = 256 -> clamp to +7.
    a1 = 64'h8888_8888_8888_8888; b1 = 64'h8888_8888_8888_8888; sat1 = 1'b1;
    run_op(1, 1'b0, lat, pulses, bcy);
    checks++;
    if (res1 !== 64'h7777_7777_7777_7777) begin errors++; $display("FAIL signed_satpos_result: got %h expected 7777777777777777", res1); end
    checks++;
    if (ovf1 !== 1'b1) begin errors++; $display("FAIL signed_satpos_ovf: got %b expected 1", ovf1); end
    // Same in wrap mode: 256 mod 16 = 0.
    sat1 = 1'b0;
    run_op(1, 1'b0, lat, pulses, bcy);
    checks++;
    if (res1 !== 64'h0) begin errors++; $display("FAIL signed_wrap_result: got %h expected 0", res1); end
    checks++;
    if (ovf1 !== 1'b1) begin errors++; $display("FAIL signed_wrap_ovf: got %b expected 1", ovf1); end
    // (-8)*7*4 = -224 -> clamp to -8.
    a1 = 64'h8888_8888_8888_8888; b1 = 64'h7777_7777_7777_7777; sat1 = 1'b1;
    run_op(1, 1'b0, lat, pulses, bcy);
    checks++;
    if (res1 !== 64'h8888_8888_8888_8888) begin errors++; $display("FAIL signed_satneg_result: got %h expected 8888888888888888", res1); end
    checks++;
    if (ovf1 !== 1'b1) begin errors++; $display("FAIL signed_satneg_ovf: got %b expected 1", ovf1); end
  endtask

  task automatic test_random_n3();
    logic [71:0] exp_res;
    logic        exp_ovf;
    int          sum, hi;
    for (int run = 0; run < 100; run++) begin
      hi = (run % 2 == 0) ? 9 : 255;
      for (int idx = 0; idx < 9; idx++) begin
        a2[8*idx +: 8] = 8'($urandom_range(0, hi));
        b2[8*idx +: 8] = 8'($urandom_range(0, hi));
      end
      sat2 = 1'($urandom_range(0, 1));
      exp_ovf = 1'b0;
      exp_res = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          sum = 0;
          for (int k = 0; k < 3; k++) sum += int'(a2[8*(r*3+k) +: 8]) * int'(b2[8*(k*3+c) +: 8]);
          if (sum > 255) begin
            exp_ovf = 1'b1;
            exp_res[8*(r*3+c) +: 8] = sat2 ? 8'hFF : 8'(sum);
          end else begin
            exp_res[8*(r*3+c) +: 8] = 8'(sum);
          end
        end
      end
      run_op(2, 1'b0, lat, pulses, bcy);
      checks++;
      if (res2 !== exp_res) begin errors++; $display("FAIL n3_result run %0d: got %h expected %h", run, res2, exp_res); end
      checks++;
      if (ovf2 !== exp_ovf) begin errors++; $display("FAIL n3_ovf run %0d: got %b expected %b", run, ovf2, exp_ovf); end
      checks++;
      if (lat != LAT3) begin errors++; $display("FAIL n3_latency run %0d: got %0d expected %0d", run, lat, LAT3); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_unsigned_overflow();
    test_capture();
    test_reset_mid_calc();
    test_signed();
    test_random_n3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
